gate_truth_table_checker: RTL and testbench

Self-test stage that consumes the 8-bit gate result bus of the two-input logic-gate block.
- Drives the gate block's a/b inputs through all four combinations.
- After a settle delay, captures the returned result byte and compares it against a built-in golden truth table.
- Reports per-vector pass/fail plus a bit-level error summary, making the gate block checkable on silicon from a single start pulse.

---
 rtl/gtt_pkg.sv | 40 ++++
 rtl/gate_truth_table_checker_golden.sv | 15 +
 rtl/gate_truth_table_checker.sv | 155 +++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtt_pkg.sv
// gtt_pkg: shared types and constants for the gate truth-table checker.
//   state_t    - checker FSM states
//   NUM_VEC    - number of (a,b) stimulus vectors
//   AND..NOTB  - bit positions of each gate inside the 8-bit result bus
//   golden()   - expected result byte for a given (a,b)
package gtt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  localparam int AND  = 0;
  localparam int OR   = 1;
  localparam int XOR  = 2;
  localparam int NAND = 3;
  localparam int NOR  = 4;
  localparam int XNOR = 5;
  localparam int NOTA = 6;
  localparam int NOTB = 7;

  function automatic logic [7:0] golden(input logic a, input logic b);
    logic [7:0] g;
    g       = '0;
    g[AND]  = a & b;
    g[OR]   = a | b;
    g[XOR]  = a ^ b;
    g[NAND] = ~(a & b);
    g[NOR]  = ~(a | b);
    g[XNOR] = ~(a ^ b);
    g[NOTA] = ~a;
    g[NOTB] = ~b;
    return g;
  endfunction

endpackage

// File: rtl/gate_truth_table_checker_golden.sv
// gate_golden_model: combinational golden truth table for the gate block.
// Ports:
//   a, b      in   stimulus pair
//   expected  out  8-bit result byte a correct gate block returns for (a,b)
module gate_golden_model
  import gtt_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);

  assign expected = golden(a, b);

endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: self-test stage for the two-input gate block.
// A start pulse walks (a,b) through (0,0),(1,0),(0,1),(1,1); each vector is
// held SETTLE_CYCLES cycles, then the returned result byte is captured and
// compared with the golden truth table.
//
// Optional feature (macro GTT_CAPTURE_LOG_EN): a 4x8 log of the raw captured
// bytes, read combinationally through rd_idx/rd_data.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begins a scan when seen in IDLE
//   gate_a/b   out  registered stimulus to the gate block
//   gate_res   in   gate block result bus (AND,OR,XOR,NAND,NOR,XNOR,NOTa,NOTb)
//   busy       out  high during SETTLE and CAPTURE
//   done       out  one-cycle pulse in the DONE state
//   pass       out  last completed scan had no mismatch
//   fail_mask  out  bit i set if vector i mismatched
//   err_bits   out  OR over all vectors of the per-bit mismatches
//   rd_idx     in   (GTT_CAPTURE_LOG_EN only) log read index
//   rd_data    out  (GTT_CAPTURE_LOG_EN only) raw captured byte at rd_idx
module gate_truth_table_checker
  import gtt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [7:0] gate_res,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] err_bits
`ifdef GTT_CAPTURE_LOG_EN
  ,
  input  logic [1:0] rd_idx,
  output logic [7:0] rd_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_VEC - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       expected;
  logic [7:0]       diff;

  // Golden byte follows idx directly; gate_a/gate_b mirror idx while busy.
  gate_golden_model u_golden (
    .a        (idx[0]),
    .b        (idx[1]),
    .expected (expected)
  );

  assign diff = gate_res ^ expected;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_bits  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          if (start) begin
            state     <= SETTLE;
            idx       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_bits  <= '0;
          end
        end

        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CAPTURE: begin
          if (diff != 8'h00) begin
            fail_mask[idx] <= 1'b1;
          end
          err_bits <= err_bits | diff;
          if (idx == IDX_LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
            // The last vector's result is not in fail_mask yet.
            pass   <= (fail_mask == 4'd0) && (diff == 8'h00);
          end else begin
            state  <= SETTLE;
            idx    <= idx + 1'b1;
            cnt    <= '0;
            // Stimulus for idx+1, registered alongside idx.
            gate_a <= ~idx[0];
            gate_b <= idx[1] ^ idx[0];
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GTT_CAPTURE_LOG_EN
  logic [7:0] log_mem [NUM_VEC];

  // NOTE: the log must read back as zero after rst/start, so it is a
  // resettable register array rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        log_mem[i] <= 8'h00;
      end
    end else if (state == CAPTURE) begin
      log_mem[idx] <= gate_res;
    end
  end

  assign rd_data = log_mem[rd_idx];
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

`ifdef GTT_CAPTURE_LOG_EN
  localparam int S = 1;
`else
  localparam int S = 2;
`endif
  localparam int L = 4 * (S + 1);   // busy cycles per scan

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gate_a, gate_b;
  logic [7:0] gate_res;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [7:0] err_bits;
`ifdef GTT_CAPTURE_LOG_EN
  logic [1:0] rd_idx;
  logic [7:0] rd_data;
`endif

  int checks   = 0;
  int failures = 0;

  // Emulated gate block: correct truth table plus injectable faults.
  logic [7:0] stuck0, stuck1;       // stuck-at-0 / stuck-at-1 bit masks
  logic [7:0] corrupt [4];          // per-vector XOR corruption
  logic       glitch_on;            // disturbance outside capture cycles
  logic [7:0] glitch_mask;

  gate_truth_table_checker #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .gate_res  (gate_res),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .err_bits  (err_bits)
`ifdef GTT_CAPTURE_LOG_EN
    ,
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
`endif
  );

  always #5 clk = ~clk;

  // Truth table from counting how many inputs are high.
  function automatic logic [7:0] tb_truth(input int a, input int b);
    int s;
    logic [7:0] t;
    s    = a + b;
    t[0] = (s == 2);
    t[1] = (s >= 1);
    t[2] = (s == 1);
    t[3] = (s != 2);
    t[4] = (s == 0);
    t[5] = (s != 1);
    t[6] = (a == 0);
    t[7] = (b == 0);
    return t;
  endfunction

  function automatic logic [7:0] clean_res(input int v);
    return ((tb_truth(v % 2, v / 2) & ~stuck0) | stuck1) ^ corrupt[v];
  endfunction

  always_comb begin
    gate_res = ((tb_truth(int'(gate_a), int'(gate_b)) & ~stuck0) | stuck1)
               ^ corrupt[{gate_b, gate_a}] ^ (glitch_on ? glitch_mask : 8'h00);
  end

  function automatic void expected_result(output logic [3:0] fm, output logic [7:0] eb);
    logic [7:0] d;
    fm = '0;
    eb = '0;
    for (int v = 0; v < 4; v++) begin
      d     = clean_res(v) ^ tb_truth(v % 2, v / 2);
      fm[v] = (d != 8'h00);
      eb    = eb | d;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    stuck0 = '0;
    stuck1 = '0;
    for (int v = 0; v < 4; v++) corrupt[v] = '0;
    glitch_on   = 1'b0;
    glitch_mask = 8'hFF;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Runs one scan from the current cycle (cycle 0) and checks every cycle.
  task automatic do_scan(input string name, input bit use_glitch);
    logic [3:0] efm;
    logic [7:0] eeb;
    int v;
    expected_result(efm, eeb);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= L; c++) begin
      v = (c - 1) / (S + 1);
      glitch_on = use_glitch && (c % (S + 1) != 0) && ($urandom_range(1) == 1);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || gate_a !== v[0] || gate_b !== v[1]) begin
        failures++;
        $display("FAIL %s cycle %0d: busy=%b done=%b ab=%b%b, required busy=1 done=0 ab=%b%b",
                 name, c, busy, done, gate_a, gate_b, v[0], v[1]);
      end
      step();
    end
    glitch_on = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (efm == 4'd0) ||
        fail_mask !== efm || err_bits !== eeb) begin
      failures++;
      $display("FAIL %s done-cycle: done=%b busy=%b pass=%b fm=%b err=%h, required 1 0 %b %b %h",
               name, done, busy, pass, fail_mask, err_bits, efm == 4'd0, efm, eeb);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== (efm == 4'd0) ||
        fail_mask !== efm || err_bits !== eeb) begin
      failures++;
      $display("FAIL %s hold: done=%b busy=%b pass=%b fm=%b err=%h, required 0 0 %b %b %h",
               name, done, busy, pass, fail_mask, err_bits, efm == 4'd0, efm, eeb);
    end
  endtask

  task automatic test_reset();
    clear_faults();
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || gate_a !== 1'b0 ||
        gate_b !== 1'b0 || fail_mask !== 4'd0 || err_bits !== 8'h00) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b pass=%b ab=%b%b fm=%b err=%h, required all zero",
               busy, done, pass, gate_a, gate_b, fail_mask, err_bits);
    end
  endtask

  task automatic test_clean_scan();
    clear_faults();
    do_scan("clean", 1'b0);
  endtask

  task automatic test_stuck_xor();
    clear_faults();
    stuck0 = 8'h04;
    do_scan("xor_stuck0", 1'b0);
    checks++;
    if (fail_mask !== 4'b0110 || err_bits !== 8'h04 || pass !== 1'b0) begin
      failures++;
      $display("FAIL xor_stuck0 result: fm=%b err=%h pass=%b, required 0110 04 0",
               fail_mask, err_bits, pass);
    end
  endtask

  task automatic test_stuck_notb_then_clean();
    clear_faults();
    stuck1 = 8'h80;
    do_scan("notb_stuck1", 1'b0);
    checks++;
    if (fail_mask !== 4'b1100 || err_bits !== 8'h80 || pass !== 1'b0) begin
      failures++;
      $display("FAIL notb_stuck1 result: fm=%b err=%h pass=%b, required 1100 80 0",
               fail_mask, err_bits, pass);
    end
    clear_faults();
    do_scan("after_notb_clean", 1'b0);
  endtask

  task automatic test_start_ignored();
    int n_done;
    clear_faults();
    n_done = 0;
    start  = 1'b1;
    step();
    for (int c = 1; c <= L + 6; c++) begin
      start = (c == 5) || (c == L + 1);
      if (done === 1'b1) n_done++;
      checks++;
      if (done !== (c == L + 1) || busy !== (c <= L)) begin
        failures++;
        $display("FAIL start_ignored cycle %0d: done=%b busy=%b, required %b %b",
                 c, done, busy, c == L + 1, c <= L);
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL start_ignored count: done pulses=%0d, required 1", n_done);
    end
  endtask

  task automatic test_start_held();
    clear_faults();
    do_reset();
    start = 1'b1;
    step();
    for (int c = 1; c <= 2 * L + 4; c++) begin
      if (c == 2 * L + 4) start = 1'b0;
      checks++;
      if (done !== ((c == L + 1) || (c == 2 * L + 3))) begin
        failures++;
        $display("FAIL start_held cycle %0d: done=%b, required %b",
                 c, done, (c == L + 1) || (c == 2 * L + 3));
      end
      step();
    end
    do_reset();
  endtask

  task automatic test_reset_mid_scan();
    clear_faults();
    stuck1 = 8'h01;   // AND stuck high: vectors 0..2 fail
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    rst = 1'b1;       // cycle 7
    step();
    rst = 1'b0;       // cycle 8
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gate_a !== 1'b0 || gate_b !== 1'b0 ||
        fail_mask !== 4'd0 || err_bits !== 8'h00 || pass !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_scan: busy=%b done=%b ab=%b%b fm=%b err=%h pass=%b, required all zero",
               busy, done, gate_a, gate_b, fail_mask, err_bits, pass);
    end
    step();
    do_scan("after_mid_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      clear_faults();
      for (int v = 0; v < 4; v++) begin
        corrupt[v] = ($urandom_range(1) == 1) ? 8'($urandom_range(255)) : 8'h00;
      end
      glitch_mask = 8'($urandom_range(255, 1));
      do_scan("random", 1'b1);
      step();
    end
  endtask

`ifdef GTT_CAPTURE_LOG_EN
  task automatic test_capture_log();
    clear_faults();
    do_reset();
    for (int v = 0; v < 4; v++) corrupt[v] = 8'($urandom_range(255));
    do_scan("log_scan", 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_data !== clean_res(i)) begin
        failures++;
        $display("FAIL log_read %0d: got %h, required %h", i, rd_data, clean_res(i));
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      checks++;
      if (rd_data !== 8'h00) begin
        failures++;
        $display("FAIL log_clear_on_start %0d: got %h, required 00", i, rd_data);
      end
    end
    do_reset();
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef GTT_CAPTURE_LOG_EN
    rd_idx = 2'd0;
`endif
    clear_faults();
    step();
    test_reset();
    test_clean_scan();
    step();
    test_stuck_xor();
    step();
    test_stuck_notb_then_clean();
    step();
    test_start_ignored();
    test_start_held();
    test_reset_mid_scan();
    step();
    test_random();
`ifdef GTT_CAPTURE_LOG_EN
    test_capture_log();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
